rx_prbs9_ber_checker: RTL and testbench

//  Receive-end PRBS9 (x^9+x^5+1) checker and BER counter for the I or Q branch; one instance per branch.

---
 rtl/rx_prbs9_ber_checker.sv | 139 +++++++++++++
 tb/tb_rx_prbs9_ber_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_prbs9_ber_checker.sv
// PRBS9 (x^9+x^5+1) receive checker: self-synchronises to the incoming stream,
// declares lock after a clean acquisition window, then counts compared bits and errors.
module rx_prbs9_ber_checker #(
  parameter int unsigned NB_CNT       = 32,
  parameter int unsigned WIN_LEN      = 128,
  parameter int unsigned ACQ_ERR_MAX  = 0,
  parameter int unsigned LOSS_ERR_MAX = 16
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_bit,
  input  logic              i_clear,
  output logic              o_locked,
  output logic              o_err,
  output logic [NB_CNT-1:0] o_bit_count,
  output logic [NB_CNT-1:0] o_err_count
);

  localparam int unsigned WIN_W = $clog2(WIN_LEN);
  localparam int unsigned ERR_W = WIN_W + 1;
  localparam logic [NB_CNT-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    SEED = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t             state;
  logic [8:0]         h;
  logic [3:0]         seed_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [ERR_W-1:0]   win_err;

  logic               exp_bit_c;
  logic               mismatch_c;
  logic [ERR_W-1:0]   win_err_tot_c;
  logic               win_end_c;
  logic               acq_pass_c;
  logic               loss_c;
  logic [NB_CNT-1:0]  bit_cnt_inc_c;
  logic [NB_CNT-1:0]  err_cnt_inc_c;

  // Prediction, window bookkeeping and saturating counter increments
  always_comb begin
    exp_bit_c     = h[8] ^ h[4];
    mismatch_c    = i_bit ^ exp_bit_c;
    win_err_tot_c = win_err + ERR_W'(mismatch_c);
    win_end_c     = (win_cnt == WIN_LAST);
    acq_pass_c    = (32'(win_err_tot_c) <= ACQ_ERR_MAX);
    loss_c        = (32'(win_err_tot_c) > LOSS_ERR_MAX);
    bit_cnt_inc_c = (o_bit_count != CNT_MAX) ? o_bit_count + NB_CNT'(1) : o_bit_count;
    err_cnt_inc_c = (mismatch_c && (o_err_count != CNT_MAX)) ?
                    o_err_count + NB_CNT'(1) : o_err_count;
  end

  // Once seeded, the history is fed with its own prediction so received errors never corrupt it
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= SEED;
      h           <= '0;
      seed_cnt    <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      o_locked    <= 1'b0;
      o_err       <= 1'b0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      o_err <= 1'b0;
      if (i_clear) begin
        o_bit_count <= '0;
        o_err_count <= '0;
      end
      if (i_valid) begin
        unique case (state)
          SEED: begin
            h <= {h[7:0], i_bit};
            if (seed_cnt == 4'd8) begin
              state    <= ACQ;
              seed_cnt <= '0;
              win_cnt  <= '0;
              win_err  <= '0;
            end else begin
              seed_cnt <= seed_cnt + 4'd1;
            end
          end
          ACQ: begin
            o_err <= mismatch_c;
            h     <= {h[7:0], exp_bit_c};
            if (win_end_c) begin
              win_cnt <= '0;
              win_err <= '0;
              if (acq_pass_c) begin
                state       <= LOCK;
                o_locked    <= 1'b1;
                o_bit_count <= '0;
                o_err_count <= '0;
              end else begin
                state    <= SEED;
                seed_cnt <= '0;
              end
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              win_err <= win_err_tot_c;
            end
          end
          LOCK: begin
            o_err <= mismatch_c;
            h     <= {h[7:0], exp_bit_c};
            if (!i_clear) begin
              o_bit_count <= bit_cnt_inc_c;
              o_err_count <= err_cnt_inc_c;
            end
            if (win_end_c) begin
              win_cnt <= '0;
              win_err <= '0;
              if (loss_c) begin
                state    <= SEED;
                o_locked <= 1'b0;
                seed_cnt <= '0;
              end
            end else begin
              win_cnt <= win_cnt + WIN_W'(1);
              win_err <= win_err_tot_c;
            end
          end
          default: begin
            state    <= SEED;
            o_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_prbs9_ber_checker.sv
// Bench for rx_prbs9_ber_checker: a PRBS9 source feeds two checkers (default and
// 4-bit-counter variants); a reference model fills a scoreboard checked after every bit.
module tb_rx_prbs9_ber_checker;

  localparam int WIN = 128;

  logic clk = 1'b0;
  logic rst_a, rst_b, valid, bit_a, bit_b, clr;
  logic locked_a, err_a, locked_b, err_b;
  logic [31:0] bits_a, errs_a;
  logic [3:0]  bits_b, errs_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rx_prbs9_ber_checker u_dut_a (
    .clk(clk), .i_reset(rst_a), .i_valid(valid), .i_bit(bit_a), .i_clear(clr),
    .o_locked(locked_a), .o_err(err_a), .o_bit_count(bits_a), .o_err_count(errs_a)
  );

  rx_prbs9_ber_checker #(.NB_CNT(4), .LOSS_ERR_MAX(WIN)) u_dut_b (
    .clk(clk), .i_reset(rst_b), .i_valid(valid), .i_bit(bit_b), .i_clear(clr),
    .o_locked(locked_b), .o_err(err_b), .o_bit_count(bits_b), .o_err_count(errs_b)
  );

  typedef struct {
    int     phase;
    int     pos;
    int     werr;
    longint bits;
    longint errs;
    logic   locked;
    logic   err;
  } model_t;

  typedef struct {
    logic        err_a;
    logic        locked_a;
    logic [31:0] bits_a;
    logic [31:0] errs_a;
    logic        err_b;
    logic        locked_b;
    logic [3:0]  bits_b;
    logic [3:0]  errs_b;
  } exp_t;

  exp_t       sb[$];
  model_t     m_a, m_b;
  logic       b_on;
  logic [8:0] tx_s;

  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.pos = 0; m.werr = 0; m.bits = 0; m.errs = 0;
    m.locked = 1'b0; m.err = 1'b0;
    return m;
  endfunction

  // phase 0 = seeding, 1 = acquiring, 2 = locked; mis = bit was inverted at the source
  function automatic model_t model_step(model_t mi, logic mis, logic c, int loss_max, longint cmax);
    model_t m = mi;
    m.err = 1'b0;
    if (c) begin m.bits = 0; m.errs = 0; end
    case (m.phase)
      0: begin
        m.pos++;
        if (m.pos == 9) begin m.phase = 1; m.pos = 0; m.werr = 0; end
      end
      1: begin
        m.err = mis;
        m.werr += int'(mis);
        m.pos++;
        if (m.pos == WIN) begin
          if (m.werr == 0) begin
            m.phase = 2; m.locked = 1'b1; m.bits = 0; m.errs = 0;
          end else begin
            m.phase = 0;
          end
          m.pos = 0; m.werr = 0;
        end
      end
      default: begin
        m.err = mis;
        if (!c) begin
          if (m.bits < cmax) m.bits++;
          if (mis && m.errs < cmax) m.errs++;
        end
        m.werr += int'(mis);
        m.pos++;
        if (m.pos == WIN) begin
          if (m.werr > loss_max) begin m.phase = 0; m.locked = 1'b0; end
          m.pos = 0; m.werr = 0;
        end
      end
    endcase
    return m;
  endfunction

  // One received bit; gap = clocks until the next bit may start (1 = back-to-back)
  task automatic send(input int gap, input logic fa, input logic fb, input logic c);
    logic tb_bit;
    exp_t e, g;
    @(negedge clk);
    tb_bit = tx_s[8] ^ tx_s[4];
    tx_s   = {tx_s[7:0], tb_bit};
    bit_a  = tb_bit ^ fa;
    bit_b  = tb_bit ^ fb;
    valid  = 1'b1;
    clr    = c;
    m_a = model_step(m_a, fa, c, 16, 64'hFFFF_FFFF);
    if (b_on) m_b = model_step(m_b, fb, c, WIN, 15);
    e.err_a = m_a.err;  e.locked_a = m_a.locked;
    e.bits_a = 32'(m_a.bits); e.errs_a = 32'(m_a.errs);
    e.err_b = m_b.err;  e.locked_b = m_b.locked;
    e.bits_b = 4'(m_b.bits);  e.errs_b = 4'(m_b.errs);
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    tests += 8;
    if (err_a !== g.err_a) begin fails++; $display("FAIL err_a: got %b expected %b", err_a, g.err_a); end
    if (locked_a !== g.locked_a) begin fails++; $display("FAIL locked_a: got %b expected %b", locked_a, g.locked_a); end
    if (bits_a !== g.bits_a) begin fails++; $display("FAIL bits_a: got %0d expected %0d", bits_a, g.bits_a); end
    if (errs_a !== g.errs_a) begin fails++; $display("FAIL errs_a: got %0d expected %0d", errs_a, g.errs_a); end
    if (err_b !== g.err_b) begin fails++; $display("FAIL err_b: got %b expected %b", err_b, g.err_b); end
    if (locked_b !== g.locked_b) begin fails++; $display("FAIL locked_b: got %b expected %b", locked_b, g.locked_b); end
    if (bits_b !== g.bits_b) begin fails++; $display("FAIL bits_b: got %0d expected %0d", bits_b, g.bits_b); end
    if (errs_b !== g.errs_b) begin fails++; $display("FAIL errs_b: got %0d expected %0d", errs_b, g.errs_b); end
    if (gap > 1) begin
      @(negedge clk);
      valid = 1'b0;
      clr   = 1'b0;
      if (g.err_a) begin
        @(posedge clk); #1;
        tests++;
        if (err_a !== 1'b0) begin fails++; $display("FAIL err_a_pulse_width: got %b expected 0", err_a); end
      end
      repeat (gap - 2) @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests += 6;
    if (locked_a !== 1'b0) begin fails++; $display("FAIL reset_locked_a: got %b expected 0", locked_a); end
    if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err_a: got %b expected 0", err_a); end
    if (bits_a !== 32'd0) begin fails++; $display("FAIL reset_bits_a: got %0d expected 0", bits_a); end
    if (errs_a !== 32'd0) begin fails++; $display("FAIL reset_errs_a: got %0d expected 0", errs_a); end
    if (locked_b !== 1'b0) begin fails++; $display("FAIL reset_locked_b: got %b expected 0", locked_b); end
    if (errs_b !== 4'd0) begin fails++; $display("FAIL reset_errs_b: got %0d expected 0", errs_b); end
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_lock_clean();
    for (int n = 1; n <= 10000; n++) begin
      send(4, 1'b0, 1'b0, 1'b0);
      if (n == 136) begin
        tests++;
        if (locked_a !== 1'b0) begin fails++; $display("FAIL lock_early_136: got %b expected 0", locked_a); end
      end
      if (n == 137) begin
        tests++;
        if (locked_a !== 1'b1) begin fails++; $display("FAIL lock_at_137: got %b expected 1", locked_a); end
      end
    end
    tests += 2;
    if (bits_a !== 32'd9863) begin fails++; $display("FAIL clean_bit_count: got %0d expected 9863", bits_a); end
    if (errs_a !== 32'd0) begin fails++; $display("FAIL clean_err_count: got %0d expected 0", errs_a); end
  endtask

  task automatic test_err_inject();
    for (int i = 0; i < 640; i++) send(2, (i % 64) == 63, 1'b0, 1'b0);
    tests += 3;
    if (errs_a !== 32'd10) begin fails++; $display("FAIL inject_err_count: got %0d expected 10", errs_a); end
    if (bits_a !== 32'd10503) begin fails++; $display("FAIL inject_bit_count: got %0d expected 10503", bits_a); end
    if (locked_a !== 1'b1) begin fails++; $display("FAIL inject_locked: got %b expected 1", locked_a); end
  endtask

  task automatic test_clear();
    send(1, 1'b0, 1'b0, 1'b1);
    idle();
    tests += 3;
    if (bits_a !== 32'd0) begin fails++; $display("FAIL clear_bits: got %0d expected 0", bits_a); end
    if (errs_a !== 32'd0) begin fails++; $display("FAIL clear_errs: got %0d expected 0", errs_a); end
    if (locked_a !== 1'b1) begin fails++; $display("FAIL clear_locked: got %b expected 1", locked_a); end
    send(1, 1'b0, 1'b0, 1'b0);
    idle();
    tests++;
    if (bits_a !== 32'd1) begin fails++; $display("FAIL clear_next_bit: got %0d expected 1", bits_a); end
  endtask

  task automatic test_back_to_back_loss();
    int align;
    align = (WIN - m_a.pos) % WIN;
    for (int i = 0; i < align; i++) send(1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < WIN; i++) send(1, 1'b1, 1'b0, 1'b0);
    idle();
    tests += 3;
    if (locked_a !== 1'b0) begin fails++; $display("FAIL loss_unlocked: got %b expected 0", locked_a); end
    if (errs_a !== 32'd128) begin fails++; $display("FAIL loss_err_hold: got %0d expected 128", errs_a); end
    if (bits_a !== 32'(1 + align + WIN)) begin fails++; $display("FAIL loss_bit_hold: got %0d expected %0d", bits_a, 1 + align + WIN); end
    for (int i = 0; i < 136; i++) send(1, 1'b0, 1'b0, 1'b0);
    idle();
    tests++;
    if (locked_a !== 1'b0) begin fails++; $display("FAIL relock_early: got %b expected 0", locked_a); end
    send(1, 1'b0, 1'b0, 1'b0);
    idle();
    tests += 3;
    if (locked_a !== 1'b1) begin fails++; $display("FAIL relock: got %b expected 1", locked_a); end
    if (bits_a !== 32'd0) begin fails++; $display("FAIL relock_bits: got %0d expected 0", bits_a); end
    if (errs_a !== 32'd0) begin fails++; $display("FAIL relock_errs: got %0d expected 0", errs_a); end
  endtask

  task automatic test_acq_error();
    @(negedge clk);
    rst_a = 1'b0;
    #2;
    tests++;
    if (locked_a !== 1'b0) begin fails++; $display("FAIL async_reset_a: got %b expected 0", locked_a); end
    m_a = model_reset();
    @(negedge clk);
    rst_a = 1'b1;
    for (int n = 1; n <= 137; n++) send(1, n == 20, 1'b0, 1'b0);
    idle();
    tests++;
    if (locked_a !== 1'b0) begin fails++; $display("FAIL acq_err_no_lock_137: got %b expected 0", locked_a); end
    for (int n = 138; n <= 273; n++) send(1, 1'b0, 1'b0, 1'b0);
    idle();
    tests++;
    if (locked_a !== 1'b0) begin fails++; $display("FAIL acq_err_early_273: got %b expected 0", locked_a); end
    send(1, 1'b0, 1'b0, 1'b0);
    idle();
    tests++;
    if (locked_a !== 1'b1) begin fails++; $display("FAIL acq_err_lock_274: got %b expected 1", locked_a); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rst_b = 1'b1;
    m_b   = model_reset();
    b_on  = 1'b1;
    for (int n = 0; n < 137; n++) send(1, 1'b0, 1'b0, 1'b0);
    idle();
    tests++;
    if (locked_b !== 1'b1) begin fails++; $display("FAIL sat_lock_b: got %b expected 1", locked_b); end
    for (int n = 0; n < 20; n++) send(1, 1'b0, 1'b1, 1'b0);
    idle();
    tests += 3;
    if (errs_b !== 4'd15) begin fails++; $display("FAIL sat_err_count: got %0d expected 15", errs_b); end
    if (bits_b !== 4'd15) begin fails++; $display("FAIL sat_bit_count: got %0d expected 15", bits_b); end
    if (locked_b !== 1'b1) begin fails++; $display("FAIL sat_still_locked: got %b expected 1", locked_b); end
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    tests += 5;
    if (locked_b !== 1'b0) begin fails++; $display("FAIL async_locked_b: got %b expected 0", locked_b); end
    if (err_b !== 1'b0) begin fails++; $display("FAIL async_err_b: got %b expected 0", err_b); end
    if (bits_b !== 4'd0) begin fails++; $display("FAIL async_bits_b: got %0d expected 0", bits_b); end
    if (errs_b !== 4'd0) begin fails++; $display("FAIL async_errs_b: got %0d expected 0", errs_b); end
    if (locked_a !== 1'b1) begin fails++; $display("FAIL async_a_unaffected: got %b expected 1", locked_a); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    valid = 1'b0; clr = 1'b0; bit_a = 1'b0; bit_b = 1'b0;
    tx_s  = 9'h1AA;
    b_on  = 1'b0;
    m_a   = model_reset();
    m_b   = model_reset();
    test_reset();
    test_lock_clean();
    test_err_inject();
    test_clear();
    test_back_to_back_loss();
    test_acq_error();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
